zoom_renderer: RTL and testbench
================================

Name: zoom_renderer

Overview:
Next-generation board renderer with a runtime-selectable zoom level, from 1x1 up to 2^LOG_ZOOM_MAX square pixels per cell. It prefetches each scanline's board words into a ping-pong row buffer during horizontal blanking, then draws cells, an optional grid and a coloured cursor through a fixed 3-cycle pixel pipeline. It sits between the xvga timing generator, the board memory read port and the VGA output pins. The board is toroidal, so views wrap at the board edges.

Parameters:
LOG_ZOOM_MAX, 4, largest log2 of the cell size in pixels.
V_TOTAL, 806, total lines per frame, including blanking.
ALIVE_COLOR, 12'hFFF, colour of a live cell.
CURSOR_COLOR, 12'hF00, colour of the cursor border.
GRID_COLOR, 12'h333, colour of grid lines.

Ports:
clk_130mhz  in  1  sole clock.
rst_n_in  in  1  asynchronous, active-low reset.
hcount_in  in  11  pixel column from xvga.
vcount_in  in  10  line number from xvga.
hsync_in, vsync_in  in  1 each  active-low syncs from xvga.
blank_in  in  1  blanking from xvga.
view_x_in, view_y_in  in  LOG_BOARD_SIZE  top-left cell of the view, in board coordinates.
cursor_x_in, cursor_y_in  in  LOG_BOARD_SIZE  cursor cell, in board coordinates.
zoom_in  in  3  requested log2 of the cell size.
grid_en_in  in  1  enables grid lines.
addr_r_out  out  LOG_MAX_ADDR  board word address.
rd_en_out  out  1  read strobe.
data_r_in  in  WORD_SIZE  board word, valid 1 cycle after the address; MSB is the lowest x.
pix_out  out  12  RGB444 pixel.
hsync_out, vsync_out  out  1 each  delayed syncs.
frame_done_out  out  1  1-cycle pulse when the frame configuration is latched.
fetch_overrun_out  out  1  sticky error flag.

Behaviour:
- Reset (async assert, sync release) drives these values:
  - pix_out=0, frame_done_out=0, rd_en_out=0, addr_r_out=0, fetch_overrun_out=0.
  - hsync_out=1, vsync_out=1.
  - Fetch FSM returns to IDLE; latched configuration clears to 0; the valid flag clears.
- Reset asserted mid-fetch aborts the fetch immediately. Row buffer contents are don't-care after reset.
- Configuration latch:
  - Fires when vcount_in==SCREEN_HEIGHT and hcount_in==0.
  - Latches view_x, view_y, cursor_x, cursor_y, grid_en and zoom. zoom_in>LOG_ZOOM_MAX clamps to LOG_ZOOM_MAX.
  - Pulses frame_done_out and sets the valid flag.
  - pix_out stays 0 until the valid flag is set.
- Target line T:
  - T=vcount_in+1 when vcount_in<SCREEN_HEIGHT-1.
  - T=0 when vcount_in==V_TOTAL-1.
  - Otherwise there is no fetch.
- Fetch FSM (IDLE -> FETCH -> DRAIN -> IDLE):
  - Starts at hcount_in==SCREEN_WIDTH whenever a target line exists.
  - N=((SCREEN_WIDTH>>zoom)+WORD_SIZE-1)/WORD_SIZE+1 words, at most SCREEN_WIDTH/WORD_SIZE+1.
  - FETCH issues k=0..N-1, one per cycle, with rd_en_out=1.
  - row=(view_y+(T>>zoom)) mod BOARD_SIZE.
  - col=((view_x>>LOG_WORD_SIZE)+k) mod WORDS_PER_ROW.
  - addr=row*WORDS_PER_ROW+col.
  - Each returned word is written 1 cycle later to bank T[0], slot k.
  - DRAIN captures the last word, then the FSM returns to IDLE.
  - If hcount_in==0 while the FSM is not IDLE: set fetch_overrun_out (sticky until reset) and abort to IDLE.
- Pixel pipeline (3 cycles, applied to pix, hsync and vsync alike):
  - S1: cx=hcount>>zoom, cy=vcount>>zoom, b=view_x[LOG_WORD_SIZE-1:0]+cx. Read bank vcount[0], slot b>>LOG_WORD_SIZE (registered read).
  - S2: alive = word bit WORD_SIZE-1-b[LOG_WORD_SIZE-1:0].
  - S2 cursor: dx=(cursor_x-view_x) mod BOARD_SIZE, dy likewise. Cursor is hit when cx==dx, cy==dy, and the pixel lies on the first or last pixel row/column of that cell. At zoom 0 the hit is the single pixel.
  - S2 grid: hit when grid_en, zoom>=2, and either hcount or vcount has its low zoom bits equal to zero.
  - S3 priority: blank -> 0; cursor -> CURSOR_COLOR; alive -> ALIVE_COLOR; grid -> GRID_COLOR; otherwise 0.
- Width rules: all board coordinate arithmetic wraps modulo BOARD_SIZE (LOG_BOARD_SIZE-bit truncation). Addresses never exceed BOARD_SIZE*WORDS_PER_ROW-1.

Decomposition:
- Shared package (common.svh) holds WORD_SIZE, LOG_WORD_SIZE, BOARD_SIZE, LOG_BOARD_SIZE, WORDS_PER_ROW, LOG_MAX_ADDR, SCREEN_WIDTH, SCREEN_HEIGHT, pos_t and a new pix_t (12-bit).
- One sub-module, zoom_row_fetch, contains the FSM, address generation and buffer write port. The pixel pipeline and buffer read stay in the top level.

Test Plan:
- Reset state: hold rst_n_in=0 mid-line -> pix_out=0, hsync_out=vsync_out=1, rd_en_out=0, fetch_overrun_out=0. Release -> pix_out stays 0 until the first frame_done_out.
- Zoom 4 fetch: view=(0,0), zoom_in=4, fetch for T=32 -> N=5 reads at addr 64..68 on consecutive cycles, starting 1 cycle after hcount_in==1024.
- Zoom 0 wrap: view_x=500, cell (3,0) alive -> pixel at hcount_in=15 shows ALIVE_COLOR 3 cycles later. Column addresses wrap 31 -> 0, and N=65.
- Cursor: zoom 3, view=(10,10), cursor=(12,11) -> CURSOR_COLOR at (16..23,8) and (16,8..15). Pixel (20,12) shows the cell or grid colour, not the cursor.
- Grid and priority: grid_en=1, zoom 2, all cells dead -> GRID_COLOR where hcount[1:0]==0 or vcount[1:0]==0. With zoom 1 -> no grid. Blanked pixels stay 0.
- Frame latch and overrun: change view_x mid-frame -> no effect until the pulse at vcount=768, hcount=0. Forcing a target fetch to start at hcount_in=1340 -> fetch_overrun_out=1 and stays 1 until reset.

Source files
------------

// File: rtl/zoom_renderer_pkg.sv
// Shared geometry, types and helpers for the zoomable board renderer.
package zoom_renderer_pkg;
  localparam int WORD_SIZE      = 16;
  localparam int LOG_WORD_SIZE  = 4;
  localparam int BOARD_SIZE     = 512;
  localparam int LOG_BOARD_SIZE = 9;
  localparam int WORDS_PER_ROW  = BOARD_SIZE / WORD_SIZE;
  localparam int LOG_WPR        = LOG_BOARD_SIZE - LOG_WORD_SIZE;
  localparam int LOG_MAX_ADDR   = LOG_BOARD_SIZE + LOG_WPR;
  localparam int SCREEN_WIDTH   = 1024;
  localparam int SCREEN_HEIGHT  = 768;
  localparam int MAX_WORDS      = SCREEN_WIDTH / WORD_SIZE + 1;
  localparam int SLOT_W         = 7;

  typedef logic [LOG_BOARD_SIZE-1:0] pos_t;
  typedef logic [11:0]               pix_t;
  typedef logic [SLOT_W-1:0]         slot_t;

  typedef enum logic [1:0] {F_IDLE, F_FETCH, F_DRAIN} fetch_state_e;

  typedef struct packed {
    pos_t       view_x;
    pos_t       view_y;
    pos_t       cursor_x;
    pos_t       cursor_y;
    logic       grid_en;
    logic [2:0] zoom;
  } cfg_t;

  typedef struct packed {
    logic                 en;
    logic                 bank;
    slot_t                slot;
    logic [WORD_SIZE-1:0] data;
  } buf_wr_t;

  // One extra word covers a view that starts mid-word.
  function automatic slot_t words_per_line(input logic [2:0] zoom);
    int unsigned cells;
    cells = SCREEN_WIDTH >> zoom;
    return slot_t'(((cells + WORD_SIZE - 1) >> LOG_WORD_SIZE) + 1);
  endfunction
endpackage

// File: rtl/zoom_renderer_row_fetch.sv
// Per-scanline board prefetch: FSM, board address generation and row buffer write port.
module zoom_row_fetch
  import zoom_renderer_pkg::*;
#(
  parameter int V_TOTAL = 806
)(
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [10:0]             hcount_in,
  input  logic [9:0]              vcount_in,
  input  pos_t                    view_x_in,
  input  pos_t                    view_y_in,
  input  logic [2:0]              zoom_in,
  input  logic [WORD_SIZE-1:0]    data_r_in,
  output logic [LOG_MAX_ADDR-1:0] addr_r_out,
  output logic                    rd_en_out,
  output buf_wr_t                 buf_wr_out,
  output logic                    fetch_overrun_out
);
  fetch_state_e state_q, state_d;
  slot_t        k_q, k_d, n_q, n_d, wr_slot_q, wr_slot_d;
  pos_t         row_q, row_d;
  logic         bank_q, bank_d, wr_en_q, wr_en_d, wr_bank_q, wr_bank_d;
  logic         overrun_q, overrun_d;
  logic [9:0]   tgt;
  logic         has_tgt, abort, fetching;
  logic [LOG_WPR-1:0] col;

  always_comb begin
    has_tgt = 1'b0;
    tgt     = '0;
    if (vcount_in < 10'(SCREEN_HEIGHT - 1)) begin
      has_tgt = 1'b1;
      tgt     = vcount_in + 10'd1;
    end else if (vcount_in == 10'(V_TOTAL - 1)) begin
      has_tgt = 1'b1;
    end
  end

  // A fetch still running when the next line starts would corrupt the bank being shown.
  assign abort = (hcount_in == '0) && (state_q != F_IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= F_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      F_IDLE:  if (hcount_in == 11'(SCREEN_WIDTH) && has_tgt) state_d = F_FETCH;
      F_FETCH: if (k_q == n_q - slot_t'(1)) state_d = F_DRAIN;
      F_DRAIN: state_d = F_IDLE;
      default: state_d = F_IDLE;
    endcase
    if (abort) state_d = F_IDLE;
  end

  always_comb begin
    k_d       = k_q;
    n_d       = n_q;
    row_d     = row_q;
    bank_d    = bank_q;
    if (state_q == F_IDLE) begin
      k_d    = '0;
      n_d    = words_per_line(zoom_in);
      row_d  = view_y_in + pos_t'(tgt >> zoom_in);
      bank_d = tgt[0];
    end else if (state_q == F_FETCH) begin
      k_d = k_q + slot_t'(1);
    end
    wr_en_d   = (state_q == F_FETCH) && !abort;
    wr_slot_d = k_q;
    wr_bank_d = bank_q;
    overrun_d = overrun_q | abort;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      k_q       <= '0;
      n_q       <= '0;
      row_q     <= '0;
      bank_q    <= 1'b0;
      wr_en_q   <= 1'b0;
      wr_slot_q <= '0;
      wr_bank_q <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      k_q       <= k_d;
      n_q       <= n_d;
      row_q     <= row_d;
      bank_q    <= bank_d;
      wr_en_q   <= wr_en_d;
      wr_slot_q <= wr_slot_d;
      wr_bank_q <= wr_bank_d;
      overrun_q <= overrun_d;
    end
  end

  // Column wraps across the board width; k indexes the buffer slot directly.
  always_comb begin
    fetching        = (state_q == F_FETCH);
    col             = view_x_in[LOG_BOARD_SIZE-1:LOG_WORD_SIZE] + k_q[LOG_WPR-1:0];
    rd_en_out       = fetching;
    addr_r_out      = fetching ? {row_q, col} : '0;
    buf_wr_out.en   = wr_en_q && !abort;
    buf_wr_out.bank = wr_bank_q;
    buf_wr_out.slot = wr_slot_q;
    buf_wr_out.data = data_r_in;
  end

  assign fetch_overrun_out = overrun_q;
endmodule

// File: rtl/zoom_renderer.sv
// Zoomable toroidal board renderer: frame config latch, ping-pong row buffer, 3-stage pixel pipe.
module zoom_renderer
  import zoom_renderer_pkg::*;
#(
  parameter int   LOG_ZOOM_MAX = 4,
  parameter int   V_TOTAL      = 806,
  parameter pix_t ALIVE_COLOR  = 12'hFFF,
  parameter pix_t CURSOR_COLOR = 12'hF00,
  parameter pix_t GRID_COLOR   = 12'h333
)(
  input  logic                    clk_130mhz,
  input  logic                    rst_n_in,
  input  logic [10:0]             hcount_in,
  input  logic [9:0]              vcount_in,
  input  logic                    hsync_in,
  input  logic                    vsync_in,
  input  logic                    blank_in,
  input  logic [LOG_BOARD_SIZE-1:0] view_x_in,
  input  logic [LOG_BOARD_SIZE-1:0] view_y_in,
  input  logic [LOG_BOARD_SIZE-1:0] cursor_x_in,
  input  logic [LOG_BOARD_SIZE-1:0] cursor_y_in,
  input  logic [2:0]              zoom_in,
  input  logic                    grid_en_in,
  output logic [LOG_MAX_ADDR-1:0] addr_r_out,
  output logic                    rd_en_out,
  input  logic [WORD_SIZE-1:0]    data_r_in,
  output logic [11:0]             pix_out,
  output logic                    hsync_out,
  output logic                    vsync_out,
  output logic                    frame_done_out,
  output logic                    fetch_overrun_out
);
  localparam int         ZW       = LOG_ZOOM_MAX;
  localparam logic [2:0] ZOOM_MAX = 3'(LOG_ZOOM_MAX);

  cfg_t    cfg_q, cfg_d;
  logic    valid_q, valid_d, frame_done_q, frame_done_d, latch;
  buf_wr_t buf_wr;

  zoom_row_fetch #(.V_TOTAL(V_TOTAL)) u_fetch (
    .clk               (clk_130mhz),
    .rst_n             (rst_n_in),
    .hcount_in         (hcount_in),
    .vcount_in         (vcount_in),
    .view_x_in         (cfg_q.view_x),
    .view_y_in         (cfg_q.view_y),
    .zoom_in           (cfg_q.zoom),
    .data_r_in         (data_r_in),
    .addr_r_out        (addr_r_out),
    .rd_en_out         (rd_en_out),
    .buf_wr_out        (buf_wr),
    .fetch_overrun_out (fetch_overrun_out)
  );

  assign latch = (vcount_in == 10'(SCREEN_HEIGHT)) && (hcount_in == '0);

  always_comb begin
    cfg_d        = cfg_q;
    valid_d      = valid_q;
    frame_done_d = latch;
    if (latch) begin
      cfg_d.view_x   = view_x_in;
      cfg_d.view_y   = view_y_in;
      cfg_d.cursor_x = cursor_x_in;
      cfg_d.cursor_y = cursor_y_in;
      cfg_d.grid_en  = grid_en_in;
      cfg_d.zoom     = (zoom_in > ZOOM_MAX) ? ZOOM_MAX : zoom_in;
      valid_d        = 1'b1;
    end
  end

  // Row buffer: contents need no reset, so it lives outside the reset domain.
  logic [WORD_SIZE-1:0] row_buf [2][MAX_WORDS];
  logic [WORD_SIZE-1:0] rd_word_q;
  logic [10:0]          cx, b;
  slot_t                rd_slot, rd_idx;
  logic [ZW-1:0]        zmask;

  always_comb begin
    zmask   = ZW'((32'd1 << cfg_q.zoom) - 32'd1);
    cx      = hcount_in >> cfg_q.zoom;
    b       = 11'(cfg_q.view_x[LOG_WORD_SIZE-1:0]) + cx;
    rd_slot = b[10:LOG_WORD_SIZE];
    rd_idx  = (rd_slot < slot_t'(MAX_WORDS)) ? rd_slot : '0;
  end

  always_ff @(posedge clk_130mhz) begin
    if (buf_wr.en) row_buf[buf_wr.bank][buf_wr.slot] <= buf_wr.data;
    rd_word_q <= row_buf[vcount_in[0]][rd_idx];
  end

  // Stage 1 registers alongside the buffer read.
  pos_t                 s1_cx_q, s1_cx_d, s1_cy_q, s1_cy_d;
  logic [LOG_WORD_SIZE-1:0] s1_bit_q, s1_bit_d;
  logic [ZW-1:0]        s1_hlow_q, s1_hlow_d, s1_vlow_q, s1_vlow_d;
  logic                 s1_blank_q, s1_blank_d;
  // Stage 2 decisions.
  pos_t                 dx, dy;
  logic                 h_edge, v_edge;
  logic                 s2_blank_q, s2_blank_d, s2_cur_q, s2_cur_d;
  logic                 s2_alive_q, s2_alive_d, s2_grid_q, s2_grid_d;
  pix_t                 pix_q, pix_d;
  logic [2:0]           hs_pipe_q, hs_pipe_d, vs_pipe_q, vs_pipe_d;

  always_comb begin
    s1_cx_d    = pos_t'(cx);
    s1_cy_d    = pos_t'(vcount_in >> cfg_q.zoom);
    s1_bit_d   = b[LOG_WORD_SIZE-1:0];
    s1_hlow_d  = hcount_in[ZW-1:0] & zmask;
    s1_vlow_d  = vcount_in[ZW-1:0] & zmask;
    s1_blank_d = blank_in;

    dx         = cfg_q.cursor_x - cfg_q.view_x;
    dy         = cfg_q.cursor_y - cfg_q.view_y;
    h_edge     = (s1_hlow_q == '0) || (s1_hlow_q == zmask);
    v_edge     = (s1_vlow_q == '0) || (s1_vlow_q == zmask);
    // MSB of a board word is the lowest x, hence the inverted bit index.
    s2_alive_d = rd_word_q[~s1_bit_q];
    s2_cur_d   = (s1_cx_q == dx) && (s1_cy_q == dy) && (h_edge || v_edge);
    s2_grid_d  = cfg_q.grid_en && (cfg_q.zoom >= 3'd2) &&
                 ((s1_hlow_q == '0) || (s1_vlow_q == '0));
    s2_blank_d = s1_blank_q;

    if (!valid_q || s2_blank_q) pix_d = '0;
    else if (s2_cur_q)          pix_d = CURSOR_COLOR;
    else if (s2_alive_q)        pix_d = ALIVE_COLOR;
    else if (s2_grid_q)         pix_d = GRID_COLOR;
    else                        pix_d = '0;

    hs_pipe_d = {hs_pipe_q[1:0], hsync_in};
    vs_pipe_d = {vs_pipe_q[1:0], vsync_in};
  end

  always_ff @(posedge clk_130mhz or negedge rst_n_in) begin
    if (!rst_n_in) begin
      cfg_q        <= '0;
      valid_q      <= 1'b0;
      frame_done_q <= 1'b0;
      s1_cx_q      <= '0;
      s1_cy_q      <= '0;
      s1_bit_q     <= '0;
      s1_hlow_q    <= '0;
      s1_vlow_q    <= '0;
      s1_blank_q   <= 1'b1;
      s2_blank_q   <= 1'b1;
      s2_cur_q     <= 1'b0;
      s2_alive_q   <= 1'b0;
      s2_grid_q    <= 1'b0;
      pix_q        <= '0;
      hs_pipe_q    <= '1;
      vs_pipe_q    <= '1;
    end else begin
      cfg_q        <= cfg_d;
      valid_q      <= valid_d;
      frame_done_q <= frame_done_d;
      s1_cx_q      <= s1_cx_d;
      s1_cy_q      <= s1_cy_d;
      s1_bit_q     <= s1_bit_d;
      s1_hlow_q    <= s1_hlow_d;
      s1_vlow_q    <= s1_vlow_d;
      s1_blank_q   <= s1_blank_d;
      s2_blank_q   <= s2_blank_d;
      s2_cur_q     <= s2_cur_d;
      s2_alive_q   <= s2_alive_d;
      s2_grid_q    <= s2_grid_d;
      pix_q        <= pix_d;
      hs_pipe_q    <= hs_pipe_d;
      vs_pipe_q    <= vs_pipe_d;
    end
  end

  assign pix_out        = pix_q;
  assign hsync_out      = hs_pipe_q[2];
  assign vsync_out      = vs_pipe_q[2];
  assign frame_done_out = frame_done_q;
endmodule

// File: tb/tb_zoom_renderer.sv
// Directed bench for zoom_renderer: drives xvga counters by hand and models board memory.
module tb_zoom_renderer;
  import zoom_renderer_pkg::*;

  localparam logic [31:0] ALIVE = 32'hFFF, CURS = 32'hF00, GRID = 32'h333;

  logic        clk = 1'b0, rst_n = 1'b0;
  logic [10:0] hcount = '0;
  logic [9:0]  vcount = '0;
  logic        hsync = 1'b1, vsync = 1'b1, blank = 1'b0;
  pos_t        view_x = '0, view_y = '0, cur_x = '0, cur_y = '0;
  logic [2:0]  zoom = '0;
  logic        grid_en = 1'b0;
  logic [LOG_MAX_ADDR-1:0] addr;
  logic        rd_en, hs_o, vs_o, fdone, ovr;
  logic [WORD_SIZE-1:0] data_r = '0;
  logic [11:0] pix;

  logic [15:0] mem [0:16383];
  logic [11:0] cap    [0:2047];
  logic        hs_cap [0:2047];
  logic        vs_cap [0:2047];

  int checks = 0, failures = 0;
  int nreads, first_h, last_h;
  logic [31:0] a0, a1, alast;

  zoom_renderer dut (
    .clk_130mhz(clk), .rst_n_in(rst_n), .hcount_in(hcount), .vcount_in(vcount),
    .hsync_in(hsync), .vsync_in(vsync), .blank_in(blank),
    .view_x_in(view_x), .view_y_in(view_y), .cursor_x_in(cur_x), .cursor_y_in(cur_y),
    .zoom_in(zoom), .grid_en_in(grid_en), .addr_r_out(addr), .rd_en_out(rd_en),
    .data_r_in(data_r), .pix_out(pix), .hsync_out(hs_o), .vsync_out(vs_o),
    .frame_done_out(fdone), .fetch_overrun_out(ovr)
  );

  always #4 clk = ~clk;
  always @(posedge clk) data_r <= mem[addr];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step(input int h, input int v);
    hcount = 11'(h);
    vcount = 10'(v);
    blank  = (h >= 1024) || (v >= 768);
    hsync  = !(h >= 1048 && h < 1184);
    vsync  = !(v >= 771 && v < 777);
    @(posedge clk); #1;
  endtask

  task automatic fetch(input int v);
    nreads = 0; first_h = -1; last_h = -1; a0 = '0; a1 = '0; alast = '0;
    for (int h = 1024; h <= 1100; h++) begin
      step(h, v);
      if (rd_en) begin
        if (nreads == 0) begin first_h = h; a0 = 32'(addr); end
        if (nreads == 1) a1 = 32'(addr);
        nreads++;
        last_h = h;
        alast  = 32'(addr);
      end
    end
  endtask

  task automatic draw(input int v, input int h0, input int h1);
    for (int h = h0; h <= h1 + 2; h++) begin
      step(h, v);
      if (h - 2 >= h0) begin
        cap[h-2]    = pix;
        hs_cap[h-2] = hs_o;
        vs_cap[h-2] = vs_o;
      end
    end
  endtask

  task automatic latch_cfg();
    step(0, 768);
    chk("frame_done_pulse", 32'(fdone), 32'd1);
  endtask

  initial begin
    for (int i = 0; i < 16384; i++) mem[i] = '0;

    // Reset held mid-line with syncs asserted at the input.
    hcount = 11'd500; vcount = 10'd100; hsync = 1'b0; vsync = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_pix", 32'(pix), 32'd0);
    chk("rst_hsync", 32'(hs_o), 32'd1);
    chk("rst_vsync", 32'(vs_o), 32'd1);
    chk("rst_rd_en", 32'(rd_en), 32'd0);
    chk("rst_addr", 32'(addr), 32'd0);
    chk("rst_overrun", 32'(ovr), 32'd0);
    chk("rst_frame_done", 32'(fdone), 32'd0);
    rst_n = 1'b1;

    // Before any latch the output stays black even over live cells.
    for (int i = 32; i < 64; i++) mem[i] = 16'hFFFF;
    fetch(0);
    draw(1, 0, 10);
    chk("prelatch_pix", 32'(cap[5]), 32'd0);
    chk("prelatch_no_pulse", 32'(fdone), 32'd0);
    for (int i = 32; i < 64; i++) mem[i] = '0;

    // Zoom 4 fetch for line 32.
    zoom = 3'd4;
    mem[64] = 16'h8000;
    latch_cfg();
    step(1, 768);
    chk("frame_done_clear", 32'(fdone), 32'd0);
    step(1023, 31);
    chk("z4_idle_before", 32'(rd_en), 32'd0);
    fetch(31);
    chk("z4_nreads", 32'(nreads), 32'd5);
    chk("z4_first_h", 32'(first_h), 32'd1024);
    chk("z4_first_addr", a0, 32'd64);
    chk("z4_last_addr", alast, 32'd68);
    chk("z4_consecutive", 32'(last_h), 32'd1028);
    draw(32, 0, 20);
    chk("z4_alive", 32'(cap[5]), ALIVE);
    chk("z4_dead", 32'(cap[16]), 32'd0);

    // Zoom 0 with the view wrapping off the right edge of the board.
    view_x = 9'd500; cur_x = 9'd300; cur_y = 9'd300; zoom = 3'd0;
    mem[64] = '0;
    mem[0]  = 16'h1000;
    latch_cfg();
    fetch(805);
    chk("z0_nreads", 32'(nreads), 32'd65);
    chk("z0_addr_k0", a0, 32'd31);
    chk("z0_addr_k1", a1, 32'd0);
    draw(0, 0, 20);
    chk("z0_alive_h15", 32'(cap[15]), ALIVE);
    chk("z0_dead_h14", 32'(cap[14]), 32'd0);
    chk("z0_dead_h16", 32'(cap[16]), 32'd0);

    // Mid-frame view change is ignored until the next latch.
    view_x = 9'd0;
    fetch(805);
    draw(0, 0, 20);
    chk("hold_old_view", 32'(cap[15]), ALIVE);
    latch_cfg();
    fetch(805);
    draw(0, 0, 20);
    chk("new_view_h15", 32'(cap[15]), 32'd0);
    chk("new_view_h3", 32'(cap[3]), ALIVE);

    // Cursor border at zoom 3.
    view_x = 9'd10; view_y = 9'd10; cur_x = 9'd12; cur_y = 9'd11; zoom = 3'd3;
    latch_cfg();
    fetch(7);
    draw(8, 0, 30);
    chk("cur_top_16", 32'(cap[16]), CURS);
    chk("cur_top_23", 32'(cap[23]), CURS);
    chk("cur_left_out", 32'(cap[15]), 32'd0);
    chk("cur_right_out", 32'(cap[24]), 32'd0);
    fetch(11);
    draw(12, 0, 30);
    chk("cur_left_col", 32'(cap[16]), CURS);
    chk("cur_interior", 32'(cap[20]), 32'd0);
    chk("cur_right_col", 32'(cap[23]), CURS);

    // Grid at zoom 2, blanking and sync delay.
    view_x = 9'd100; view_y = 9'd100; cur_x = 9'd0; cur_y = 9'd0; zoom = 3'd2; grid_en = 1'b1;
    latch_cfg();
    fetch(3);
    fetch(4);
    draw(4, 0, 10);
    chk("grid_row", 32'(cap[5]), GRID);
    draw(5, 0, 10);
    chk("grid_col4", 32'(cap[4]), GRID);
    chk("grid_off5", 32'(cap[5]), 32'd0);
    chk("grid_off7", 32'(cap[7]), 32'd0);
    chk("grid_col8", 32'(cap[8]), GRID);
    draw(770, 4, 8);
    chk("blank_black", 32'(cap[4]), 32'd0);
    draw(770, 1046, 1050);
    chk("hsync_before", 32'(hs_cap[1047]), 32'd1);
    chk("hsync_delayed", 32'(hs_cap[1048]), 32'd0);
    draw(772, 4, 6);
    chk("vsync_delayed", 32'(vs_cap[4]), 32'd0);

    // Zoom 1 never draws a grid.
    zoom = 3'd1;
    latch_cfg();
    fetch(3);
    draw(4, 0, 10);
    chk("z1_no_grid4", 32'(cap[4]), 32'd0);
    chk("z1_no_grid0", 32'(cap[0]), 32'd0);

    // Oversized zoom request clamps to the maximum.
    view_x = 9'd0; view_y = 9'd0; grid_en = 1'b0; zoom = 3'd7;
    latch_cfg();
    fetch(31);
    chk("clamp_nreads", 32'(nreads), 32'd5);
    chk("clamp_addr", a0, 32'd64);

    // Fetch started late enough to still be running at the next line start.
    zoom = 3'd0;
    latch_cfg();
    step(1024, 10);
    for (int h = 1340; h <= 1343; h++) step(h, 10);
    chk("ovr_not_yet", 32'(ovr), 32'd0);
    step(0, 10);
    chk("ovr_set", 32'(ovr), 32'd1);
    chk("ovr_abort", 32'(rd_en), 32'd0);
    step(1, 10);
    step(2, 10);
    chk("ovr_sticky", 32'(ovr), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("ovr_reset", 32'(ovr), 32'd0);
    chk("reset_pix", 32'(pix), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
